// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_decoder
//  Purpose  : Receive side of the morse link. Samples an on/off key line on
//             half-second ticks, times each mark and space, classifies marks
//             as dot or dash, collects up to MAX_SYM symbols and decodes the
//             letters A..H back to their 3-bit letter code.
//  Ports    : clk          - system clock, all state on rising edge
//             reset        - asynchronous active-high reset
//             half_sec     - one-cycle tick enable, key_in sampled only then
//             key_in       - key/light line, 1 = mark
//             letter_out   - last decoded letter (A=0 .. H=7), held until next
//             letter_valid - one-cycle pulse, letter_out updated
//             letter_err   - one-cycle pulse, letter rejected
//             sym_count    - symbols collected in current letter (debug)
//             state        - FSM state (debug): IDLE=0, MARK=1, SPACE=2
//  Revision : 1.0 - initial release
// ============================================================================
module morse_decoder #(
    parameter int DASH_MIN   = 2,
    parameter int MARK_MAX   = 3,
    parameter int LETTER_GAP = 3,
    parameter int MAX_SYM    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       half_sec,
    input  logic       key_in,
    output logic [2:0] letter_out,
    output logic       letter_valid,
    output logic       letter_err,
    output logic [2:0] sym_count,
    output logic [1:0] state
);

    // Mark counter must hold MARK_MAX+1 (saturation value marking "too long").
    localparam int MW   = $clog2(MARK_MAX + 2);
    localparam int SW   = $clog2(LETTER_GAP + 1);
    // The decode table is defined over four symbol positions.
    localparam int SYMW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;

    localparam logic [MW-1:0] C_DASH_MIN = MW'(DASH_MIN);
    localparam logic [MW-1:0] C_MARK_MAX = MW'(MARK_MAX);
    localparam logic [MW-1:0] C_MARK_SAT = MW'(MARK_MAX + 1);
    localparam logic [SW-1:0] C_GAP      = SW'(LETTER_GAP);
    localparam logic [2:0]    C_MAX_SYM  = 3'(MAX_SYM);

    logic [1:0]      state_q,     state_d;
    logic [MW-1:0]   mark_cnt_q,  mark_cnt_d;
    logic [SW-1:0]   space_cnt_q, space_cnt_d;
    logic [SYMW-1:0] sym_q,       sym_d;
    logic [2:0]      sym_cnt_q,   sym_cnt_d;
    logic            err_flag_q,  err_flag_d;
    logic [2:0]      letter_q,    letter_d;
    logic            valid_q,     valid_d;
    logic            lerr_q,      lerr_d;

    logic            dec_hit;
    logic [2:0]      dec_code;
    logic            is_dash;

    // Decode table: symbol i lives in bit i, dash=1, dot=0. Bits above
    // sym_cnt_q are always zero because the register is cleared per letter.
    always_comb begin
        dec_hit  = 1'b0;
        dec_code = 3'd0;
        case (sym_cnt_q)
            3'd1: if (sym_q == 4'b0000) begin dec_hit = 1'b1; dec_code = 3'd4; end // E .
            3'd2: if (sym_q == 4'b0010) begin dec_hit = 1'b1; dec_code = 3'd0; end // A .-
            3'd3: begin
                case (sym_q)
                    4'b0001: begin dec_hit = 1'b1; dec_code = 3'd3; end // D -..
                    4'b0011: begin dec_hit = 1'b1; dec_code = 3'd6; end // G --.
                    default: ;
                endcase
            end
            3'd4: begin
                case (sym_q)
                    4'b0001: begin dec_hit = 1'b1; dec_code = 3'd1; end // B -...
                    4'b0101: begin dec_hit = 1'b1; dec_code = 3'd2; end // C -.-.
                    4'b0100: begin dec_hit = 1'b1; dec_code = 3'd5; end // F ..-.
                    4'b0000: begin dec_hit = 1'b1; dec_code = 3'd7; end // H ....
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Overlong marks are flagged as errors; their stored bit is irrelevant.
    assign is_dash = (mark_cnt_q >= C_DASH_MIN);

    always_comb begin
        state_d     = state_q;
        mark_cnt_d  = mark_cnt_q;
        space_cnt_d = space_cnt_q;
        sym_d       = sym_q;
        sym_cnt_d   = sym_cnt_q;
        err_flag_d  = err_flag_q;
        letter_d    = letter_q;
        valid_d     = 1'b0;
        lerr_d      = 1'b0;

        if (half_sec) begin
            case (state_q)
                S_IDLE: begin
                    if (key_in) begin
                        state_d    = S_MARK;
                        mark_cnt_d = MW'(1);
                    end
                end
                S_MARK: begin
                    if (key_in) begin
                        if (mark_cnt_q != C_MARK_SAT) begin
                            mark_cnt_d = mark_cnt_q + 1'b1;
                        end
                    end else begin
                        if (mark_cnt_q > C_MARK_MAX) begin
                            err_flag_d = 1'b1;
                        end
                        if (sym_cnt_q == C_MAX_SYM) begin
                            err_flag_d = 1'b1;
                        end else begin
                            sym_d     = sym_q | (SYMW'(is_dash) << sym_cnt_q);
                            sym_cnt_d = sym_cnt_q + 1'b1;
                        end
                        // The low tick that ends the mark is the first gap tick.
                        state_d     = S_SPACE;
                        space_cnt_d = SW'(1);
                    end
                end
                S_SPACE: begin
                    if (key_in) begin
                        state_d    = S_MARK;
                        mark_cnt_d = MW'(1);
                    end else if ((space_cnt_q + SW'(1)) == C_GAP) begin
                        state_d     = S_IDLE;
                        space_cnt_d = '0;
                        if (!err_flag_q && dec_hit) begin
                            letter_d = dec_code;
                            valid_d  = 1'b1;
                        end else begin
                            lerr_d   = 1'b1;
                        end
                        sym_d      = '0;
                        sym_cnt_d  = 3'd0;
                        err_flag_d = 1'b0;
                    end else begin
                        space_cnt_d = space_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mark_cnt_q  <= '0;
            space_cnt_q <= '0;
            sym_q       <= '0;
            sym_cnt_q   <= 3'd0;
            err_flag_q  <= 1'b0;
            letter_q    <= 3'd0;
            valid_q     <= 1'b0;
            lerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            space_cnt_q <= space_cnt_d;
            sym_q       <= sym_d;
            sym_cnt_q   <= sym_cnt_d;
            err_flag_q  <= err_flag_d;
            letter_q    <= letter_d;
            valid_q     <= valid_d;
            lerr_q      <= lerr_d;
        end
    end

    assign letter_out   = letter_q;
    assign letter_valid = valid_q;
    assign letter_err   = lerr_q;
    assign sym_count    = sym_cnt_q;
    assign state        = state_q;

endmodule
`default_nettype wire
